// File: rtl/io_decode_pkg.sv
// rtl/io_decode_pkg.sv - shared widths and FSM encodings for the IO window decoder
package io_decode_pkg;
  localparam int BASE_W = 12;
  localparam int WAIT_W = 4;
  localparam int TO_W   = 8;
  localparam int IDX_W  = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_TOUT = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;
endpackage

// File: rtl/io_window_match.sv
// rtl/io_window_match.sv - combinational 16-byte window compare with lowest-index priority
module io_window_match
  import io_decode_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [BASE_W-1:0]        i_addr,
  input  logic [NUM_CH*BASE_W-1:0] i_ch_base,
  output logic [NUM_CH-1:0]        o_match,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_hit
);

  // Walk from the top down so the lowest matching channel is the last writer.
  always_comb begin
    o_match = '0;
    o_idx   = '0;
    o_hit   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      o_match[i] = (i_addr == i_ch_base[i*BASE_W +: BASE_W]);
      if (o_match[i]) begin
        o_idx = i[IDX_W-1:0];
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_chip_select_dtack.sv
// rtl/io_chip_select_dtack.sv - IO window decoder producing chip selects, access strobe, DTACK and BERR
module io_chip_select_dtack
  import io_decode_pkg::*;
#(
  parameter int                         NUM_CH       = 4,
  parameter logic [NUM_CH*BASE_W-1:0]   CH_BASE      = {12'h803, 12'h802, 12'h801, 12'h800},
  parameter logic [NUM_CH*WAIT_W-1:0]   CH_WAIT      = {4'd3, 4'd1, 4'd0, 4'd0},
  parameter int                         BERR_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Reset_H,
  input  logic [31:0]       Address,
  input  logic              IOSelect_H,
  input  logic              AS_L,
  input  logic              UDS_L,
  input  logic              LDS_L,
  output logic [NUM_CH-1:0] CS_H,
  output logic              Strobe_H,
  output logic              Dtack_L,
  output logic              Berr_L,
  output logic              Busy_H
);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_ch;
  logic [TO_W-1:0]   r_cnt;
  logic              r_ack_seen;

  logic              w_start;
  logic [NUM_CH-1:0] w_match;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hit;
  logic [WAIT_W-1:0] w_wait;
  logic [NUM_CH-1:0] w_cs_sel;
  logic              w_unused_addr;

  assign w_unused_addr = ^{Address[31:16], Address[3:0], w_match};
  assign w_start = ~AS_L & IOSelect_H & (~UDS_L | ~LDS_L);

  io_window_match #(.NUM_CH(NUM_CH)) u_match (
    .i_addr    (Address[15:4]),
    .i_ch_base (CH_BASE),
    .o_match   (w_match),
    .o_idx     (w_idx),
    .o_hit     (w_hit)
  );

  always_comb begin
    w_wait = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_idx == i[IDX_W-1:0]) w_wait = CH_WAIT[i*WAIT_W +: WAIT_W];
    end
  end

  always_comb begin
    w_cs_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cs_sel[i] = (r_ch == i[IDX_W-1:0]);
    end
  end

  // Abort on AS_L high takes precedence over a counter expiring on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_hit) begin
              r_state <= ST_WAIT;
              r_ch    <= w_idx;
              r_cnt   <= {{(TO_W-WAIT_W){1'b0}}, w_wait};
            end else begin
              r_state <= ST_TOUT;
              r_cnt   <= TO_W'(BERR_TIMEOUT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (AS_L)              r_state <= ST_IDLE;
          else if (r_cnt == '0)  r_state <= ST_ACK;
          else                   r_cnt   <= r_cnt - 1'b1;
        end
        ST_ACK: begin
          if (AS_L) r_state <= ST_IDLE;
        end
        ST_TOUT: begin
          if (AS_L)              r_state <= ST_IDLE;
          else if (r_cnt == '0)  r_state <= ST_ERR;
          else                   r_cnt   <= r_cnt - 1'b1;
        end
        ST_ERR: begin
          if (AS_L) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs follow the state one cycle later, so nothing combinational reaches the pins.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      CS_H       <= '0;
      Strobe_H   <= 1'b0;
      Dtack_L    <= 1'b1;
      Berr_L     <= 1'b1;
      Busy_H     <= 1'b0;
      r_ack_seen <= 1'b0;
    end else begin
      CS_H       <= (r_state == ST_WAIT || r_state == ST_ACK) ? w_cs_sel : '0;
      Strobe_H   <= (r_state == ST_ACK) && !r_ack_seen;
      Dtack_L    <= (r_state != ST_ACK);
      Berr_L     <= (r_state != ST_ERR);
      Busy_H     <= (r_state != ST_IDLE);
      r_ack_seen <= (r_state == ST_ACK);
    end
  end

endmodule

// File: tb/tb_io_chip_select_dtack.sv
// tb/tb_io_chip_select_dtack.sv - directed-vector bench for io_chip_select_dtack
module tb_io_chip_select_dtack;

  logic        Clk = 1'b0;
  logic        Reset_H;
  logic [31:0] Address;
  logic        IOSelect_H, AS_L, UDS_L, LDS_L;
  logic [3:0]  CS_H;
  logic        Strobe_H, Dtack_L, Berr_L, Busy_H;
  logic [1:0]  CS2_H;
  logic        Strobe2_H, Dtack2_L, Berr2_L, Busy2_H;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes;
  int bad;

  always #5 Clk = ~Clk;

  io_chip_select_dtack u_dut (
    .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .IOSelect_H(IOSelect_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .CS_H(CS_H), .Strobe_H(Strobe_H),
    .Dtack_L(Dtack_L), .Berr_L(Berr_L), .Busy_H(Busy_H)
  );

  io_chip_select_dtack #(
    .NUM_CH(2), .CH_BASE({12'h802, 12'h802}), .CH_WAIT({4'd0, 4'd0}), .BERR_TIMEOUT(64)
  ) u_dut2 (
    .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .IOSelect_H(IOSelect_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .CS_H(CS2_H), .Strobe_H(Strobe2_H),
    .Dtack_L(Dtack2_L), .Berr_L(Berr2_L), .Busy_H(Busy2_H)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_acc(input logic [31:0] a);
    Address    = a;
    IOSelect_H = 1'b1;
    AS_L       = 1'b0;
    UDS_L      = 1'b0;
    LDS_L      = 1'b1;
  endtask

  task automatic end_acc();
    AS_L       = 1'b1;
    UDS_L      = 1'b1;
    LDS_L      = 1'b1;
    IOSelect_H = 1'b0;
  endtask

  initial begin
    Reset_H = 1'b1;
    Address = '0;
    end_acc();
    repeat (3) tick();
    check("rst_cs",     32'(CS_H), 32'h0);
    check("rst_dtack",  32'(Dtack_L), 32'h1);
    check("rst_berr",   32'(Berr_L), 32'h1);
    check("rst_strobe", 32'(Strobe_H), 32'h0);
    check("rst_busy",   32'(Busy_H), 32'h0);
    Reset_H = 1'b0;
    tick();

    // channel 2, one wait state
    start_acc(32'h0040_8020);
    tick();
    tick();
    check("t1_cs_n1",    32'(CS_H), 32'h4);
    check("t1_dtack_n1", 32'(Dtack_L), 32'h1);
    check("t1_busy_n1",  32'(Busy_H), 32'h1);
    tick();
    check("t1_dtack_n2", 32'(Dtack_L), 32'h1);
    tick();
    check("t1_dtack_n3", 32'(Dtack_L), 32'h0);
    check("t1_strb_n3",  32'(Strobe_H), 32'h1);
    tick();
    check("t1_strb_n4",  32'(Strobe_H), 32'h0);
    end_acc();
    tick();
    check("t1_dtack_m",  32'(Dtack_L), 32'h0);
    tick();
    check("t1_cs_m1",    32'(CS_H), 32'h0);
    check("t1_dtack_m1", 32'(Dtack_L), 32'h1);
    check("t1_busy_m1",  32'(Busy_H), 32'h0);

    // channel 3, three wait states, AS_L held 20 cycles
    start_acc(32'h0040_8030);
    tick();
    strobes = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Strobe_H) strobes++;
      if (k == 1) check("t2_cs_n1",    32'(CS_H), 32'h8);
      if (k == 4) check("t2_dtack_n4", 32'(Dtack_L), 32'h1);
      if (k == 5) check("t2_dtack_n5", 32'(Dtack_L), 32'h0);
    end
    check("t2_strobes", 32'(strobes), 32'd1);
    end_acc();
    tick();
    tick();
    check("t2_cs_end", 32'(CS_H), 32'h0);

    // unmapped access times out into BERR
    start_acc(32'h0040_9000);
    tick();
    bad = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (Dtack_L !== 1'b1 || CS_H !== 4'h0) bad++;
      if (k == 64) check("t3_berr_n64", 32'(Berr_L), 32'h1);
      if (k == 65) check("t3_berr_n65", 32'(Berr_L), 32'h0);
    end
    check("t3_no_ack",    32'(bad), 32'd0);
    check("t3_berr_hold", 32'(Berr_L), 32'h0);
    end_acc();
    tick();
    tick();
    check("t3_berr_rel", 32'(Berr_L), 32'h1);

    // abort in WAIT, then immediate access to channel 0
    start_acc(32'h0040_8030);
    tick();
    tick();
    check("t4_cs_n1", 32'(CS_H), 32'h8);
    AS_L = 1'b1;
    tick();
    check("t4_strb_n2",  32'(Strobe_H), 32'h0);
    check("t4_dtack_n2", 32'(Dtack_L), 32'h1);
    start_acc(32'h0040_8000);
    tick();
    check("t4_cs_idle",  32'(CS_H), 32'h0);
    check("t4_strb_n3",  32'(Strobe_H), 32'h0);
    check("t4_dtack_n3", 32'(Dtack_L), 32'h1);
    tick();
    check("t4_cs_ch0",   32'(CS_H), 32'h1);
    tick();
    check("t4_dtack_ch0", 32'(Dtack_L), 32'h0);
    check("t4_strb_ch0",  32'(Strobe_H), 32'h1);
    end_acc();
    tick();
    tick();

    // reset during ACK
    start_acc(32'h0040_8000);
    tick();
    tick();
    tick();
    check("t5_dtack_ack", 32'(Dtack_L), 32'h0);
    Reset_H = 1'b1;
    tick();
    check("t5a_cs",    32'(CS_H), 32'h0);
    check("t5a_dtack", 32'(Dtack_L), 32'h1);
    check("t5a_strb",  32'(Strobe_H), 32'h0);
    check("t5a_berr",  32'(Berr_L), 32'h1);
    check("t5a_busy",  32'(Busy_H), 32'h0);
    end_acc();
    tick();
    Reset_H = 1'b0;
    tick();

    // reset during ERR
    start_acc(32'h0040_9000);
    repeat (66) tick();
    check("t5_berr_err", 32'(Berr_L), 32'h0);
    Reset_H = 1'b1;
    tick();
    check("t5e_berr",  32'(Berr_L), 32'h1);
    check("t5e_busy",  32'(Busy_H), 32'h0);
    check("t5e_cs",    32'(CS_H), 32'h0);
    check("t5e_dtack", 32'(Dtack_L), 32'h1);
    end_acc();
    tick();
    Reset_H = 1'b0;
    tick();

    // two identical windows: lowest channel wins
    start_acc(32'h0040_8020);
    tick();
    tick();
    check("t6_cs2_n1",    32'(CS2_H), 32'h1);
    tick();
    check("t6_dtack2_n2", 32'(Dtack2_L), 32'h0);
    end_acc();
    tick();
    tick();
    check("t6_cs2_end", 32'(CS2_H), 32'h0);

    // no data strobe: never leaves IDLE
    Address    = 32'h0040_8020;
    IOSelect_H = 1'b1;
    AS_L       = 1'b0;
    UDS_L      = 1'b1;
    LDS_L      = 1'b1;
    repeat (5) tick();
    check("t6_nods_busy",  32'(Busy_H), 32'h0);
    check("t6_nods_busy2", 32'(Busy2_H), 32'h0);
    check("t6_nods_cs2",   32'(CS2_H), 32'h0);
    end_acc();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
